task_scheduler: RTL and testbench
=================================

// Module: task_scheduler
// PURPOSE
//   Single-core scheduler for the task FSM bank. Scans N packed task words {id,prio}, picks the
//   highest-priority ready task and issues Execute. Holds it for a fixed quantum, then issues
//   Finish Execution. Host commands (Ready/Suspend/Wait/Kill/SetPrio/SetHit) merge onto the shared
//   16-bit op bus in gaps between scheduler commands.
// PARAMETERS
//   N_TASKS   8   number of task slots scanned (1..15)
//   QUANTUM   16  RUN-state cycles per dispatch (>=1)
//   CNT_W     16  width of the dispatch counter
// PORTS
//   CLK          in   1        system clock; sole clock, all state on rising edge
//   RST          in   1        synchronous, active-high reset
//   en           in   1        scheduler enable; 0 = stay/return to IDLE after current FINISH
//   task_words   in   8*N      slot i at [8i+7:8i]; [7:4]=task id, [3:0]=priority; 8'h00 = not ready
//   host_op      in   16       host command, same format as op_out
//   host_valid   in   1        host_op valid
//   host_ready   out  1        host_op accepted this cycle when host_valid & host_ready
//   op_out       out  16       {4'h0, id[3:0], opcode[3:0], arg[3:0]} to all task FSMs
//   op_valid     out  1        op_out valid this cycle
//   cur_id       out  4        id of task in RUN; 0 otherwise
//   busy         out  1        1 in ISSUE/RUN/FINISH
//   preempt      out  1        1-cycle pulse: running task dropped out of ready during RUN
//   dispatches   out  CNT_W    completed quanta, saturates at all-ones
// BEHAVIOUR
//   Reset: state=IDLE; op_out=0, op_valid=0, cur_id=0, busy=0, preempt=0, dispatches=0,
//     best regs cleared. RST mid-operation aborts immediately; no Finish is issued.
//   States: IDLE -> SCAN -> ISSUE -> RUN -> FINISH -> IDLE.
//   IDLE: if en, go to SCAN next cycle; clear best_prio/best_idx/best_valid.
//   SCAN: one slot per cycle, idx 0..N-1 (N cycles). Slot is a candidate iff word!=0 and id!=0.
//     Candidate replaces best iff !best_valid or prio > best_prio (strict).
//     Ties go to the lowest index. After slot N-1: go to ISSUE if best_valid, else IDLE.
//   ISSUE (1 cycle): op_out={4'h0,best_id,4'h7,4'h0}, op_valid=1; latch cur_id; load timer=QUANTUM.
//   RUN: timer decrements each cycle; at timer==1 go to FINISH.
//     If task_words[best_idx] reads 8'h00 in any RUN cycle: pulse preempt, go to IDLE,
//     no Finish, dispatches unchanged.
//   FINISH (1 cycle): op_out={4'h0,cur_id,4'hF,4'h0}, op_valid=1; dispatches+=1 (saturating).
//     Next state IDLE; cur_id returns to 0.
//   Host path: host_ready = (state==IDLE || SCAN || RUN). On accept, op_out=host_op and
//     op_valid=1 that same cycle (combinational pass-through, no latency).
//     ISSUE/FINISH own the bus and hold host_ready=0; host_valid must stay asserted.
//   Simultaneous: scheduler command always wins over host in ISSUE/FINISH; no op is ever dropped.
//   en deasserted during SCAN/RUN: the current sequence completes normally; remain in IDLE afterwards.
//   Task words are sampled live each cycle; changes during SCAN affect only slots not yet scanned.
// STRUCTURE
//   Shared package sched_pkg: opcode constants (OP_READY=1, SUSPEND=2, WAIT=3, KILL=4,
//     SETPRIO=5, SETHIT=6, EXEC=7, FINISH=F), op field positions, state enum, task word slicing.
//   One sub-module: sched_quantum_timer (load/decrement/expire, QUANTUM parameter).
//   Scan comparator, FSM and op mux stay inline.
// TESTING
//   1 Reset: RST=1 for 2 cycles mid-RUN -> op_valid=0, cur_id=0, busy=0, dispatches=0 next cycle.
//   2 Pick: N=8, slots 2={8,3}, 5={9,7}, 6={A,7}, others 0 -> after 8 SCAN cycles
//     op_out=16'h0970. QUANTUM cycles later op_out=16'h09F0; dispatches=1.
//   3 Empty bank: all words 0, en=1 -> SCAN/IDLE loop; op_valid never asserted; busy stays 0.
//   4 Preempt: running id 9 word forced to 0 on RUN cycle 4 -> preempt pulse one cycle, IDLE.
//     No 16'h09F0 issued; dispatches unchanged.
//   5 Host merge: host_op=16'h0852 held valid while entering ISSUE -> host_ready=0 during ISSUE.
//     Host op appears on op_out the first RUN cycle; EXEC op also appears, exactly once.
//   6 Saturation: CNT_W=2 override, 5 full quanta -> dispatches=3, no wrap.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared definitions for the task scheduler: op encoding, FSM states and task word slicing.
package sched_pkg;

  localparam logic [3:0] OP_READY   = 4'h1;
  localparam logic [3:0] OP_SUSPEND = 4'h2;
  localparam logic [3:0] OP_WAIT    = 4'h3;
  localparam logic [3:0] OP_KILL    = 4'h4;
  localparam logic [3:0] OP_SETPRIO = 4'h5;
  localparam logic [3:0] OP_SETHIT  = 4'h6;
  localparam logic [3:0] OP_EXEC    = 4'h7;
  localparam logic [3:0] OP_FINISH  = 4'hF;

  localparam int unsigned OP_ID_LSB   = 8;
  localparam int unsigned OP_CODE_LSB = 4;
  localparam int unsigned OP_ARG_LSB  = 0;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StIssue,
    StRun,
    StFinish
  } sched_state_e;

  function automatic logic [15:0] make_op(logic [3:0] id, logic [3:0] code, logic [3:0] arg);
    logic [15:0] op;
    op = '0;
    op[OP_ID_LSB +: 4]   = id;
    op[OP_CODE_LSB +: 4] = code;
    op[OP_ARG_LSB +: 4]  = arg;
    return op;
  endfunction

  function automatic logic [3:0] word_id(logic [7:0] word);
    return word[7:4];
  endfunction

  function automatic logic [3:0] word_prio(logic [7:0] word);
    return word[3:0];
  endfunction

endpackage

// File: rtl/sched_quantum_timer.sv
// Quantum timer: loads QUANTUM, counts down while enabled, flags the last cycle of the quantum.
module sched_quantum_timer #(
  parameter int unsigned QUANTUM = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic dec,
  output logic expire
);

  localparam int unsigned TW = $clog2(QUANTUM + 1);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= TW'(QUANTUM);
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = (cnt_q == TW'(1));

endmodule

// File: rtl/task_scheduler.sv
// Single-core task scheduler: scans task slots, dispatches the best ready task for a fixed
// quantum and merges host commands onto the shared op bus when the scheduler is not using it.
module task_scheduler #(
  parameter int unsigned N_TASKS = 8,
  parameter int unsigned QUANTUM = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 en,
  input  logic [8*N_TASKS-1:0] task_words,
  input  logic [15:0]          host_op,
  input  logic                 host_valid,
  output logic                 host_ready,
  output logic [15:0]          op_out,
  output logic                 op_valid,
  output logic [3:0]           cur_id,
  output logic                 busy,
  output logic                 preempt,
  output logic [CNT_W-1:0]     dispatches
);
  import sched_pkg::*;

  sched_state_e     state_q, state_d;
  logic [3:0]       scan_idx_q, scan_idx_d;
  logic [3:0]       best_idx_q, best_idx_d;
  logic [3:0]       best_prio_q, best_prio_d;
  logic [3:0]       best_id_q, best_id_d;
  logic             best_valid_q, best_valid_d;
  logic [3:0]       cur_id_q, cur_id_d;
  logic [CNT_W-1:0] disp_q, disp_d;

  logic [7:0] scan_word, run_word;
  logic       take;
  logic       tmr_load, tmr_dec, tmr_expire;

  assign scan_word = task_words[8*int'(scan_idx_q) +: 8];
  assign run_word  = task_words[8*int'(best_idx_q) +: 8];
  // Strict compare keeps the earliest slot on equal priority.
  assign take = (scan_word != 8'h00) && (word_id(scan_word) != 4'h0) &&
                (!best_valid_q || (word_prio(scan_word) > best_prio_q));

  sched_quantum_timer #(
    .QUANTUM(QUANTUM)
  ) u_timer (
    .CLK   (CLK),
    .RST   (RST),
    .load  (tmr_load),
    .dec   (tmr_dec),
    .expire(tmr_expire)
  );

  always_comb begin
    state_d      = state_q;
    scan_idx_d   = scan_idx_q;
    best_idx_d   = best_idx_q;
    best_prio_d  = best_prio_q;
    best_id_d    = best_id_q;
    best_valid_d = best_valid_q;
    cur_id_d     = cur_id_q;
    disp_d       = disp_q;
    op_out       = '0;
    op_valid     = 1'b0;
    preempt      = 1'b0;
    host_ready   = 1'b0;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;

    unique case (state_q)
      StIdle: begin
        host_ready   = 1'b1;
        scan_idx_d   = '0;
        best_idx_d   = '0;
        best_prio_d  = '0;
        best_id_d    = '0;
        best_valid_d = 1'b0;
        if (en) state_d = StScan;
      end
      StScan: begin
        host_ready = 1'b1;
        if (take) begin
          best_idx_d   = scan_idx_q;
          best_prio_d  = word_prio(scan_word);
          best_id_d    = word_id(scan_word);
          best_valid_d = 1'b1;
        end
        if (scan_idx_q == 4'(N_TASKS - 1)) begin
          state_d = (best_valid_q || take) ? StIssue : StIdle;
        end else begin
          scan_idx_d = scan_idx_q + 4'd1;
        end
      end
      StIssue: begin
        op_out   = make_op(best_id_q, OP_EXEC, 4'h0);
        op_valid = 1'b1;
        cur_id_d = best_id_q;
        tmr_load = 1'b1;
        state_d  = StRun;
      end
      StRun: begin
        host_ready = 1'b1;
        tmr_dec    = 1'b1;
        if (run_word == 8'h00) begin
          preempt  = 1'b1;
          cur_id_d = '0;
          state_d  = StIdle;
        end else if (tmr_expire) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        op_out   = make_op(cur_id_q, OP_FINISH, 4'h0);
        op_valid = 1'b1;
        if (disp_q != '1) disp_d = disp_q + 1'b1;
        cur_id_d = '0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Host ops pass straight through; ISSUE/FINISH never raise host_ready.
    if (host_ready && host_valid) begin
      op_out   = host_op;
      op_valid = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      scan_idx_q   <= '0;
      best_idx_q   <= '0;
      best_prio_q  <= '0;
      best_id_q    <= '0;
      best_valid_q <= 1'b0;
      cur_id_q     <= '0;
      disp_q       <= '0;
    end else begin
      state_q      <= state_d;
      scan_idx_q   <= scan_idx_d;
      best_idx_q   <= best_idx_d;
      best_prio_q  <= best_prio_d;
      best_id_q    <= best_id_d;
      best_valid_q <= best_valid_d;
      cur_id_q     <= cur_id_d;
      disp_q       <= disp_d;
    end
  end

  assign cur_id     = (state_q == StRun) ? cur_id_q : 4'h0;
  assign busy       = (state_q == StIssue) || (state_q == StRun) || (state_q == StFinish);
  assign dispatches = disp_q;

endmodule

// File: tb/tb_task_scheduler.sv
// Directed bench for task_scheduler with an op-stream scoreboard and a saturation instance.
module tb_task_scheduler;

  logic        CLK = 1'b0;
  logic        RST;
  logic        en;
  logic [63:0] words;
  logic [15:0] host_op;
  logic        host_valid;
  logic        host_ready;
  logic [15:0] op_out;
  logic        op_valid;
  logic [3:0]  cur_id;
  logic        busy;
  logic        preempt;
  logic [15:0] dispatches;

  logic        s_en;
  logic [63:0] s_words;
  logic [15:0] s_host_op;
  logic        s_host_valid;
  logic        s_host_ready;
  logic [15:0] s_op_out;
  logic        s_op_valid;
  logic [3:0]  s_cur_id;
  logic        s_busy;
  logic        s_preempt;
  logic [1:0]  s_dispatches;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_op;

  always #5 CLK = ~CLK;

  task_scheduler #(
    .N_TASKS(8),
    .QUANTUM(16),
    .CNT_W  (16)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .en        (en),
    .task_words(words),
    .host_op   (host_op),
    .host_valid(host_valid),
    .host_ready(host_ready),
    .op_out    (op_out),
    .op_valid  (op_valid),
    .cur_id    (cur_id),
    .busy      (busy),
    .preempt   (preempt),
    .dispatches(dispatches)
  );

  task_scheduler #(
    .N_TASKS(8),
    .QUANTUM(2),
    .CNT_W  (2)
  ) dut_sat (
    .CLK       (CLK),
    .RST       (RST),
    .en        (s_en),
    .task_words(s_words),
    .host_op   (s_host_op),
    .host_valid(s_host_valid),
    .host_ready(s_host_ready),
    .op_out    (s_op_out),
    .op_valid  (s_op_valid),
    .cur_id    (s_cur_id),
    .busy      (s_busy),
    .preempt   (s_preempt),
    .dispatches(s_dispatches)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Every op on the main bus must match the next scoreboard entry, in order.
  always @(negedge CLK) begin
    if (!RST && op_valid) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_op observed=%0h expected=none", op_out);
      end
      if (exp_q.size() != 0) begin
        exp_op = exp_q.pop_front();
        check("op_stream", {16'h0, op_out}, {16'h0, exp_op});
      end
    end
  end

  initial begin
    int fin;
    RST = 1'b1;
    en = 1'b0;
    words = '0;
    host_op = '0;
    host_valid = 1'b0;
    s_en = 1'b0;
    s_words = '0;
    s_host_op = '0;
    s_host_valid = 1'b0;
    tick(2);
    RST = 1'b0;
    tick(1);
    check("rst_op_valid", {31'h0, op_valid}, 32'h0);
    check("rst_cur_id", {28'h0, cur_id}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_preempt", {31'h0, preempt}, 32'h0);
    check("rst_dispatches", {16'h0, dispatches}, 32'h0);

    // Pick: slot 5 {9,7} beats slot 6 {A,7} on tie, slot 2 {8,3} on priority.
    words[8*2 +: 8] = 8'h83;
    words[8*5 +: 8] = 8'h97;
    words[8*6 +: 8] = 8'hA7;
    exp_q.push_back(16'h0970);
    exp_q.push_back(16'h09F0);
    en = 1'b1;
    tick(1);
    en = 1'b0;
    check("scan_busy", {31'h0, busy}, 32'h0);
    tick(8);
    check("issue_op", {16'h0, op_out}, 32'h0970);
    check("issue_busy", {31'h0, busy}, 32'h1);
    check("issue_host_ready", {31'h0, host_ready}, 32'h0);
    tick(1);
    check("run_cur_id", {28'h0, cur_id}, 32'h9);
    tick(15);
    check("run_last_valid", {31'h0, op_valid}, 32'h0);
    tick(1);
    check("finish_op", {16'h0, op_out}, 32'h09F0);
    tick(1);
    check("pick_dispatches", {16'h0, dispatches}, 32'h1);
    check("idle_cur_id", {28'h0, cur_id}, 32'h0);
    check("idle_busy", {31'h0, busy}, 32'h0);

    // Empty bank: scanning loops without ever going busy or driving the bus.
    words = '0;
    en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (busy !== 1'b0) check("empty_busy", {31'h0, busy}, 32'h0);
    end
    check("empty_busy_end", {31'h0, busy}, 32'h0);
    en = 1'b0;
    tick(12);

    // Preempt on RUN cycle 4.
    words[8*2 +: 8] = 8'h83;
    words[8*5 +: 8] = 8'h97;
    words[8*6 +: 8] = 8'hA7;
    exp_q.push_back(16'h0970);
    en = 1'b1;
    tick(1);
    en = 1'b0;
    tick(9);
    tick(3);
    words[8*5 +: 8] = 8'h00;
    #1;
    check("preempt_pulse", {31'h0, preempt}, 32'h1);
    tick(1);
    check("preempt_clear", {31'h0, preempt}, 32'h0);
    check("preempt_idle", {31'h0, busy}, 32'h0);
    tick(25);
    check("preempt_dispatches", {16'h0, dispatches}, 32'h1);
    words[8*5 +: 8] = 8'h97;

    // Reset mid-RUN aborts without a Finish.
    exp_q.push_back(16'h0970);
    en = 1'b1;
    tick(1);
    en = 1'b0;
    tick(8);
    tick(3);
    check("pre_reset_busy", {31'h0, busy}, 32'h1);
    RST = 1'b1;
    tick(2);
    check("midrst_op_valid", {31'h0, op_valid}, 32'h0);
    check("midrst_cur_id", {28'h0, cur_id}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_dispatches", {16'h0, dispatches}, 32'h0);
    RST = 1'b0;
    tick(20);

    // Host op held into ISSUE lands on the first RUN cycle.
    exp_q.push_back(16'h0970);
    exp_q.push_back(16'h0852);
    exp_q.push_back(16'h09F0);
    en = 1'b1;
    tick(1);
    en = 1'b0;
    tick(8);
    host_op = 16'h0852;
    host_valid = 1'b1;
    #1;
    check("merge_issue_ready", {31'h0, host_ready}, 32'h0);
    check("merge_issue_op", {16'h0, op_out}, 32'h0970);
    tick(1);
    check("merge_run_ready", {31'h0, host_ready}, 32'h1);
    check("merge_run_op", {16'h0, op_out}, 32'h0852);
    tick(1);
    host_valid = 1'b0;
    tick(15);
    tick(1);
    check("merge_dispatches", {16'h0, dispatches}, 32'h1);
    check("scoreboard_empty", exp_q.size(), 32'h0);

    // Saturation: 2-bit counter, five full quanta.
    s_words[8*0 +: 8] = 8'h11;
    s_en = 1'b1;
    fin = 0;
    for (int i = 0; i < 300 && fin < 5; i++) begin
      tick(1);
      if (s_op_valid && s_op_out[7:4] == 4'hF) fin++;
    end
    s_en = 1'b0;
    check("sat_quanta", fin, 32'd5);
    tick(20);
    check("sat_dispatches", {30'h0, s_dispatches}, 32'h3);
    check("sat_busy", {31'h0, s_busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
